// File: rtl/dqs_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dqs_tx_pkg
//  Description : Shared types and constants for the write-DQS burst
//                generator. It holds the FSM state encoding, the per-state
//                slot words (TX strobe bits and OE bits), the slot geometry,
//                and a helper that maps a state to its slot word.
//  Revision    : 1.0 - initial release
// ============================================================================
package dqs_tx_pkg;

    localparam int SLOTS_PER_CYCLE = 4;
    localparam int BITS_PER_SLOT   = 2;
    localparam int TX_W            = SLOTS_PER_CYCLE * BITS_PER_SLOT;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRE   = 2'd1,
        ST_BURST = 2'd2,
        ST_POST  = 2'd3
    } state_t;

    typedef struct packed {
        logic [TX_W-1:0]            tx;
        logic [SLOTS_PER_CYCLE-1:0] oe;
    } slot_word_t;

    // Slot words are listed with bit0 first in time. Each tCK slot holds
    // two strobe bits.
    localparam logic [TX_W-1:0]            IDLE_TX  = 8'h00;
    localparam logic [SLOTS_PER_CYCLE-1:0] IDLE_OE  = 4'h0;
    // The 1 tCK preamble drives the last slot low.
    localparam logic [TX_W-1:0]            PRE1_TX  = 8'h00;
    localparam logic [SLOTS_PER_CYCLE-1:0] PRE1_OE  = 4'b1000;
    // The 2 tCK preamble has a toggle in slot 2 and a low level in slot 3.
    localparam logic [TX_W-1:0]            PRE2_TX  = 8'h10;
    localparam logic [SLOTS_PER_CYCLE-1:0] PRE2_OE  = 4'b1100;
    // During a burst, DQS_t is high in the first half of every tCK.
    localparam logic [TX_W-1:0]            BURST_TX = 8'h55;
    localparam logic [SLOTS_PER_CYCLE-1:0] BURST_OE = 4'hF;
    // The postamble is one tCK low, placed in the first slot.
    localparam logic [TX_W-1:0]            POST_TX  = 8'h00;
    localparam logic [SLOTS_PER_CYCLE-1:0] POST_OE  = 4'b0001;

    function automatic slot_word_t word_for_state(input state_t st,
                                                  input logic   pre_2t);
        slot_word_t w;
        w.tx = IDLE_TX;
        w.oe = IDLE_OE;
        case (st)
            ST_PRE: begin
                w.tx = pre_2t ? PRE2_TX : PRE1_TX;
                w.oe = pre_2t ? PRE2_OE : PRE1_OE;
            end
            ST_BURST: begin
                w.tx = BURST_TX;
                w.oe = BURST_OE;
            end
            ST_POST: begin
                w.tx = POST_TX;
                w.oe = POST_OE;
            end
            default: begin
                w.tx = IDLE_TX;
                w.oe = IDLE_OE;
            end
        endcase
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dqs_tx_phase_shift.sv
`default_nettype none
// ============================================================================
//  Module      : dqs_tx_phase_shift
//  Description : Places the internal slot word at a tCK slot offset within
//                the fabric cycle. Output slot k takes internal slot k-p of
//                the current word when k >= p. Otherwise it takes slot
//                k-p+4 of the previous word, which arrives through the carry
//                input. The result is registered.
//  Ports       : clk, rst (async, active-high)
//                i_cur_tx/i_cur_oe     - current internal slot word
//                i_carry_tx/i_carry_oe - previous cycle's internal slot word
//                i_phase               - latched slot offset (0-3)
//                o_tx_data/o_oe_data   - registered shifted word
//  Revision    : 1.0 - initial release
// ============================================================================
module dqs_tx_phase_shift
    import dqs_tx_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [TX_W-1:0]            i_cur_tx,
    input  logic [SLOTS_PER_CYCLE-1:0] i_cur_oe,
    input  logic [TX_W-1:0]            i_carry_tx,
    input  logic [SLOTS_PER_CYCLE-1:0] i_carry_oe,
    input  logic [1:0]                 i_phase,
    output logic [TX_W-1:0]            o_tx_data,
    output logic [SLOTS_PER_CYCLE-1:0] o_oe_data
);

    // The carry word sits in slots 0-3 and the current word sits in slots
    // 4-7. Output slot k is then concatenated slot k+4-p, so a right shift
    // by (4-p) slots selects the whole output window at once.
    logic [2:0]                   w_shift_slots;
    logic [2*TX_W-1:0]            w_cat_tx;
    logic [2*SLOTS_PER_CYCLE-1:0] w_cat_oe;
    logic [2*TX_W-1:0]            w_sh_tx;
    logic [2*SLOTS_PER_CYCLE-1:0] w_sh_oe;

    always_comb begin
        w_shift_slots = 3'd4 - {1'b0, i_phase};
        w_cat_tx      = {i_cur_tx, i_carry_tx};
        w_cat_oe      = {i_cur_oe, i_carry_oe};
        w_sh_tx       = w_cat_tx >> {w_shift_slots, 1'b0};
        w_sh_oe       = w_cat_oe >> w_shift_slots;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_tx_data <= '0;
            o_oe_data <= '0;
        end else begin
            o_tx_data <= w_sh_tx[TX_W-1:0];
            o_oe_data <= w_sh_oe[SLOTS_PER_CYCLE-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/dqs_tx_burst_gen.sv
`default_nettype none
// ============================================================================
//  Module      : dqs_tx_burst_gen
//  Description : Write-DQS strobe generator for one DDR4 byte lane. It emits
//                an 8-bit TX word and a 4-bit OE word per fabric cycle for
//                the DQS IOD. The sequence is preamble, BL8 toggle burst,
//                postamble, then tri-state. Placement is sub-cycle (tCK
//                slot offset), and back-to-back bursts are seamless.
//  Ports       : FAB_CLK  - fabric clock (one cycle = 4 tCK)
//                ARST     - async active-high reset
//                WR_REQ   - single-cycle write-burst request
//                WR_PHASE - tCK slot offset, sampled with WR_REQ
//                TX_DATA  - strobe bits, bit0 first in time
//                OE_DATA  - per-slot output enable, bit0 first in time
//                BUSY     - burst in progress or OE still spilling
//                ERR      - one-cycle pulse for an illegal request
//  Revision    : 1.0 - initial release
// ============================================================================
module dqs_tx_burst_gen
    import dqs_tx_pkg::*;
#(
    parameter bit PREAMBLE_2T = 1'b0
) (
    input  logic       FAB_CLK,
    input  logic       ARST,
    input  logic       WR_REQ,
    input  logic [1:0] WR_PHASE,
    output logic [7:0] TX_DATA,
    output logic [3:0] OE_DATA,
    output logic       BUSY,
    output logic       ERR
);

    state_t                     r_state;
    state_t                     w_next_state;
    logic [1:0]                 r_phase;
    logic [TX_W-1:0]            r_carry_tx;
    logic [SLOTS_PER_CYCLE-1:0] r_carry_oe;
    logic                       r_err;
    logic                       w_latch_phase;
    logic                       w_err;
    slot_word_t                 w_word;

    // Next-state logic and request legality.
    always_comb begin
        w_next_state  = r_state;
        w_latch_phase = 1'b0;
        w_err         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (WR_REQ) begin
                    w_next_state  = ST_PRE;
                    w_latch_phase = 1'b1;
                end
            end
            ST_PRE: begin
                // The preamble cannot be restarted or extended.
                w_next_state = ST_BURST;
                w_err        = WR_REQ;
            end
            ST_BURST: begin
                if (WR_REQ) begin
                    // A seamless burst keeps the running phase. A different
                    // phase cannot be honored without a gap.
                    w_next_state = ST_BURST;
                    w_err        = (WR_PHASE != r_phase);
                end else begin
                    w_next_state = ST_POST;
                end
            end
            ST_POST: begin
                if (WR_REQ) begin
                    w_next_state  = ST_PRE;
                    w_latch_phase = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_word = word_for_state(r_state, PREAMBLE_2T);
    end

    always_ff @(posedge FAB_CLK or posedge ARST) begin
        if (ARST) begin
            r_state    <= ST_IDLE;
            r_phase    <= 2'd0;
            r_carry_tx <= '0;
            r_carry_oe <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_carry_tx <= w_word.tx;
            r_carry_oe <= w_word.oe;
            r_err      <= w_err;
            if (w_latch_phase) begin
                r_phase <= WR_PHASE;
            end
        end
    end

    dqs_tx_phase_shift u_shift (
        .clk        (FAB_CLK),
        .rst        (ARST),
        .i_cur_tx   (w_word.tx),
        .i_cur_oe   (w_word.oe),
        .i_carry_tx (r_carry_tx),
        .i_carry_oe (r_carry_oe),
        .i_phase    (r_phase),
        .o_tx_data  (TX_DATA),
        .o_oe_data  (OE_DATA)
    );

    // BUSY covers the cycle after POST. In that cycle the carry may still
    // hold enabled slots that spill into the output.
    assign BUSY = (r_state != ST_IDLE) || (r_carry_oe != '0);
    assign ERR  = r_err;

endmodule
`default_nettype wire

// File: doc/dqs_tx_burst_gen.md
Name: dqs_tx_burst_gen

Overview:
- Fabric-side write-DQS strobe generator for one DDR4 PHY byte lane.
- Produces the per-FAB_CLK 8-bit TX_DATA and 4-bit OE_DATA words that the lane's DQS IOD serializes onto DQS/DQS_N: write preamble, BL8 toggle burst, postamble, then tri-state.
- Supports sub-cycle placement in tCK slots (0-3) and seamless back-to-back bursts.
- Sits between the write-command scheduler and the DQS IOD TX path.

Parameters:
PREAMBLE_2T, 0, 0 = 1 tCK write preamble; 1 = 2 tCK write preamble.

Ports:
FAB_CLK  input  1  fabric clock; one cycle = 4 tCK = 8 strobe bits.
ARST  input  1  reset, asynchronous, active-high.
WR_REQ  input  1  write-burst request, single-cycle qualifier.
WR_PHASE  input  2  tCK slot offset of the burst within the fabric cycle; sampled with WR_REQ.
TX_DATA  output  8  strobe bits to the IOD; bit0 is first in time; slot k = bits[2k+1:2k].
OE_DATA  output  4  output enable per tCK slot to the IOD; bit0 is first in time.
BUSY  output  1  high whenever state is not IDLE, or when the carry holds a non-zero OE.
ERR  output  1  one-cycle pulse flagging an illegal request.

Behaviour:
- Reset: ARST high immediately forces state=IDLE, carry=0, phase register=0, TX_DATA=8'h00, OE_DATA=4'h0, BUSY=0, ERR=0. This applies mid-burst as well.
- States: IDLE, PRE, BURST, POST. All transitions occur on the FAB_CLK rising edge.
  - IDLE + WR_REQ -> PRE; latch WR_PHASE.
  - PRE -> BURST unconditionally. A WR_REQ seen in PRE is ignored and pulses ERR.
  - BURST + WR_REQ -> BURST (seamless: no postamble, no new preamble). If WR_PHASE differs from the latched phase: ERR pulse, request still honored at the latched phase.
  - BURST, no WR_REQ -> POST.
  - POST + WR_REQ -> PRE; latch the new WR_PHASE.
  - POST, no WR_REQ -> IDLE.
- Internal slot word per state (TX bits / OE):
  - IDLE: 8'h00 / 4'h0.
  - PRE with PREAMBLE_2T=0: 8'h00 / 4'b1000.
  - PRE with PREAMBLE_2T=1: 8'h10 / 4'b1100.
  - BURST: 8'h55 / 4'hF (DQS_t high in the first half of each tCK).
  - POST: 8'h00 / 4'b0001 (1 tCK low postamble).
- Phase shift: output slot k takes internal slot (k-p) of the current word when k>=p, otherwise internal slot (k-p+4) of the previous cycle's word (carry register). p is the latched phase.
- Outputs are registered. Latency: WR_REQ at cycle n -> state PRE at n+1 -> shifted preamble word on TX_DATA/OE_DATA at n+2.
- With p>0, trailing slots spill into the cycle after POST. BUSY stays high until the carry's OE is 0.
- ERR is registered, so it appears one cycle after the offending WR_REQ.

Decomposition:
- Package dqs_tx_pkg holds:
  - state enum (IDLE/PRE/BURST/POST);
  - slot word constants: PRE1_TX/OE, PRE2_TX/OE, BURST_TX/OE, POST_TX/OE, IDLE;
  - SLOTS_PER_CYCLE=4 and BITS_PER_SLOT=2.
- One sub-module, dqs_tx_phase_shift: takes the current word, the phase and the carry register, and produces the registered shifted TX_DATA/OE_DATA.

Test Plan:
1. Assert ARST during BURST -> TX_DATA=8'h00, OE_DATA=4'h0, BUSY=0 before the next clock edge. After release with no WR_REQ, outputs stay 0.
2. PREAMBLE_2T=0, WR_PHASE=0, WR_REQ@n -> expected outputs:
   - n+2: 00/1000
   - n+3: 55/1111
   - n+4: 00/0001
   - n+5: 00/0000, BUSY=0
3. PREAMBLE_2T=0, WR_PHASE=2, WR_REQ@n -> expected outputs:
   - n+2: 00/0000
   - n+3: 8'h50/4'b1110
   - n+4: 8'h05/4'b0111
   - n+5: 00/0000
4. WR_REQ@n and @n+2, phase 0 -> expected outputs:
   - n+2: 00/1000
   - n+3 and n+4: 55/1111
   - n+5: 00/0001
   - n+6: idle
5. WR_REQ@n and @n+1 (during PRE) -> ERR=1 at n+2 only; single burst output as in test 2. Separately, seamless request with mismatched WR_PHASE -> ERR pulse and the burst continues at the original phase.
6. PREAMBLE_2T=1, phase 0, WR_REQ@n -> n+2: TX_DATA=8'h10, OE_DATA=4'b1100; n+3: 55/1111.
